// File: rtl/memory_arbiter_if.sv
// Bus bundle between the instruction/data clients, the arbiter and the memory.
//
// Handshake: a client raises *_req with its fields stable and holds them until
// the cycle in which the arbiter raises the matching *_ready. That cycle is the
// transfer. The response is a single-cycle *_rvalid pulse on the same port.
// A request dropped before ready is simply never transferred.
interface memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_len;
  logic              d_ready;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_len;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_len, mem_rdata,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_len, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_len, mem_rdata,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_len, busy
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single fixed-latency
// memory. One access in flight at a time; data has priority except when the
// instruction port has lost STARVE_LIMIT contested grants in a row.
module memory_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  memory_arbiter_if.slave bus,
  output logic [1:0]      dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [3:0]        lat_q, lat_d;
  logic              owner_q, owner_d;   // 0 = instruction, 1 = data
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        len_q, len_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              accept_win;
  logic              grant_i, grant_d;

  // Arbitration: ready only in IDLE/RESP, never both; gated by reset so the
  // ready outputs drop the instant reset asserts.
  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    accept_win = reset_n && ((state_q == IDLE) || (state_q == RESP));
    if (accept_win) begin
      if (bus.i_req && bus.d_req) begin
        if (starve_q == STARVE_MAX) grant_i = 1'b1;
        else                        grant_d = 1'b1;
      end else if (bus.i_req) begin
        grant_i = 1'b1;
      end else if (bus.d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Next-state, capture and starvation bookkeeping.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    lat_d     = lat_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    len_d     = len_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE:  state_d = IDLE;
      // The strobe cycle always passes through WAIT, which samples memory once
      // the counter is exhausted; with latency 1 that is the very next cycle.
      ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 4'd0) begin
          if (!owner_q) i_rdata_d = bus.mem_rdata;
          else          d_rdata_d = we_q ? '0 : bus.mem_rdata;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (grant_i) begin
      owner_d  = 1'b0;
      we_d     = 1'b0;
      addr_d   = bus.i_addr;
      wdata_d  = '0;
      len_d    = 3'b010;
      starve_d = 4'd0;
      state_d  = ISSUE;
    end else if (grant_d) begin
      owner_d  = 1'b1;
      we_d     = bus.d_we;
      addr_d   = bus.d_addr;
      wdata_d  = bus.d_wdata;
      len_d    = bus.d_len;
      if (!bus.i_req)                starve_d = 4'd0;
      else if (starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
      state_d  = ISSUE;
    end
  end

  // State and captured-field registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      starve_q  <= 4'd0;
      lat_q     <= 4'd0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      len_q     <= 3'd0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      lat_q     <= lat_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      len_q     <= len_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.i_ready   = grant_i;
  assign bus.d_ready   = grant_d;
  assign bus.i_rvalid  = (state_q == RESP) && !owner_q;
  assign bus.d_rvalid  = (state_q == RESP) && owner_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_len   = len_q;
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: instance A (latency 1, starve limit 4) runs directed,
// reset, starvation and random traffic against a reference memory; instance B
// (latency 3) checks back-to-back instruction throughput.
module tb_memory_arbiter;
  localparam int ML_A = 1;
  localparam int SL_A = 4;
  localparam int ML_B = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  int   cyc = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();
  logic [1:0] dbg_a, dbg_b;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(ML_A), .STARVE_LIMIT(SL_A)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a), .dbg_state(dbg_a));
  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(ML_B), .STARVE_LIMIT(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b), .dbg_state(dbg_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'h0050_0093;
    return 32'hA000_0000 ^ (32'(idx) * 32'h0101_1357);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
  endfunction

  // ---------------- memory device for A ----------------
  logic [31:0] dev_mem [16];
  logic        dev_init = 1'b0;
  logic        pv  [ML_A];
  logic [3:0]  pix [ML_A];
  always @(posedge clock) begin
    if (!dev_init) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= init_word(i);
      dev_init <= 1'b1;
    end else if (bus_a.mem_en && bus_a.mem_we) begin
      dev_mem[bus_a.mem_addr[5:2]] <= bus_a.mem_wdata;
    end
    pv[0]  <= bus_a.mem_en && !bus_a.mem_we;
    pix[0] <= bus_a.mem_addr[5:2];
    for (int i = 1; i < ML_A; i++) begin
      pv[i]  <= pv[i-1];
      pix[i] <= pix[i-1];
    end
  end
  assign bus_a.mem_rdata = pv[ML_A-1] ? dev_mem[pix[ML_A-1]] : 32'hBAD0_BAD0;

  // memory device for B: constant word, only valid in the correct cycle
  logic [ML_B-1:0] pb = '0;
  always @(posedge clock) pb <= {pb[ML_B-2:0], bus_b.mem_en};
  assign bus_b.mem_rdata = pb[ML_B-1] ? 32'h1234_5678 : 32'hBAD0_BAD0;

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];       // {port (1 = data), data}
  int          exp_cyc_q[$];
  logic [67:0] iss_q[$];       // {we, len, addr, wdata}
  int          iss_cyc_q[$];
  logic [31:0] ref_mem [16];
  logic        ref_init = 1'b0;
  int          run = 0;        // consecutive contested data grants
  logic [31:0] last_i = '0, last_d = '0;
  bit          acc_i = 1'b0, acc_d = 1'b0;
  bit          grant_log[$];   // 1 = instruction grant
  int          expb_q[$];
  int          acc_b_q[$];

  function automatic logic [31:0] ref_rd(input logic [3:0] ix);
    return ref_mem[ix];
  endfunction

  // ---------------- monitor A ----------------
  always @(negedge clock) begin : mon_a
    logic [32:0] e;
    logic [67:0] s;
    int          ec;
    bit          win_i, rv_any, was_busy;
    logic [3:0]  ix;
    logic [31:0] rd;
    if (!ref_init) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      ref_init = 1'b1;
    end
    if (!reset_n) begin
      check({bus_a.busy, bus_a.mem_en, bus_a.mem_we, bus_a.mem_len, bus_a.i_ready, bus_a.d_ready,
             bus_a.i_rvalid, bus_a.d_rvalid} == 10'd0, "reset_ctrl",
            {bus_a.busy, bus_a.mem_en, bus_a.mem_we, bus_a.mem_len, bus_a.i_ready, bus_a.d_ready,
             bus_a.i_rvalid, bus_a.d_rvalid}, 0);
      check(bus_a.mem_addr == 32'd0, "reset_mem_addr", bus_a.mem_addr, 0);
      check(bus_a.mem_wdata == 32'd0, "reset_mem_wdata", bus_a.mem_wdata, 0);
      check(bus_a.i_rdata == 32'd0 && bus_a.d_rdata == 32'd0, "reset_rdata",
            {bus_a.i_rdata, bus_a.d_rdata}, 0);
      check(dbg_a == 2'd0 && dbg_b == 2'd0 && !bus_b.busy, "reset_state", {dbg_a, dbg_b, bus_b.busy}, 0);
      exp_q.delete(); exp_cyc_q.delete(); iss_q.delete(); iss_cyc_q.delete();
      run = 0; last_i = '0; last_d = '0; acc_i = 1'b0; acc_d = 1'b0;
    end else begin
      was_busy = (exp_q.size() != 0);
      rv_any   = bus_a.i_rvalid || bus_a.d_rvalid;
      check(bus_a.busy == was_busy, "busy", bus_a.busy, was_busy);
      check(!(bus_a.i_ready && bus_a.d_ready), "both_ready", {bus_a.i_ready, bus_a.d_ready}, 0);
      if (bus_a.i_ready || bus_a.d_ready)
        check((!was_busy || rv_any) && ((bus_a.i_ready && bus_a.i_req) || (bus_a.d_ready && bus_a.d_req)),
              "ready_window", {bus_a.i_ready, bus_a.d_ready, was_busy, rv_any}, 0);
      // memory strobe against the captured request
      if (bus_a.mem_en) begin
        check(iss_q.size() != 0, "mem_en_expected", 1, 0);
        if (iss_q.size() != 0) begin
          s  = iss_q.pop_front();
          ec = iss_cyc_q.pop_front();
          check(cyc == ec, "issue_cycle", cyc, ec);
          check(bus_a.mem_addr == s[63:32], "mem_addr", bus_a.mem_addr, s[63:32]);
          check(bus_a.mem_we == s[67], "mem_we", bus_a.mem_we, s[67]);
          check(bus_a.mem_len == s[66:64], "mem_len", bus_a.mem_len, s[66:64]);
          if (s[67]) check(bus_a.mem_wdata == s[31:0], "mem_wdata", bus_a.mem_wdata, s[31:0]);
        end
      end
      // responses
      if (rv_any) begin
        check(!(bus_a.i_rvalid && bus_a.d_rvalid), "both_rvalid", {bus_a.i_rvalid, bus_a.d_rvalid}, 1);
        check(exp_q.size() != 0, "rvalid_expected", 1, 0);
        if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          rd = e[32] ? bus_a.d_rdata : bus_a.i_rdata;
          check(cyc == ec, "resp_cycle", cyc, ec);
          check(bus_a.d_rvalid == e[32], "resp_port", bus_a.d_rvalid, e[32]);
          check(rd == e[31:0], "resp_data", rd, e[31:0]);
        end
        if (bus_a.i_rvalid) last_i = bus_a.i_rdata;
        if (bus_a.d_rvalid) last_d = bus_a.d_rdata;
      end
      if (!bus_a.i_rvalid) check(bus_a.i_rdata == last_i, "i_rdata_hold", bus_a.i_rdata, last_i);
      if (!bus_a.d_rvalid) check(bus_a.d_rdata == last_d, "d_rdata_hold", bus_a.d_rdata, last_d);
      // accepts: arbitration rule and expected response
      acc_i = bus_a.i_ready;
      acc_d = bus_a.d_ready;
      if (bus_a.i_ready || bus_a.d_ready) begin
        if (bus_a.i_req && bus_a.d_req) begin
          win_i = (run == SL_A);
          check(bus_a.i_ready == win_i, "arbitration", bus_a.i_ready, win_i);
        end
        if (bus_a.i_ready) begin
          ix = bus_a.i_addr[5:2];
          exp_q.push_back({1'b0, ref_rd(ix)});
          iss_q.push_back({1'b0, 3'b010, bus_a.i_addr, 32'h0});
          run = 0;
          grant_log.push_back(1'b1);
        end else begin
          ix = bus_a.d_addr[5:2];
          if (bus_a.d_we) begin
            ref_mem[ix] = bus_a.d_wdata;
            exp_q.push_back({1'b1, 32'h0});
          end else begin
            exp_q.push_back({1'b1, ref_rd(ix)});
          end
          iss_q.push_back({bus_a.d_we, bus_a.d_len, bus_a.d_addr, bus_a.d_wdata});
          if (!bus_a.i_req)    run = 0;
          else if (run < SL_A) run = run + 1;
          grant_log.push_back(1'b0);
        end
        exp_cyc_q.push_back(cyc + ML_A + 2);
        iss_cyc_q.push_back(cyc + 1);
      end
    end
  end

  // ---------------- monitor B ----------------
  always @(negedge clock) begin : mon_b
    int ec;
    if (reset_n) begin
      if (bus_b.i_ready) begin
        expb_q.push_back(cyc + ML_B + 2);
        acc_b_q.push_back(cyc);
      end
      if (bus_b.mem_en) check(bus_b.mem_addr == 32'h20, "b_mem_addr", bus_b.mem_addr, 32'h20);
      if (bus_b.i_rvalid) begin
        check(expb_q.size() != 0, "b_rvalid_expected", 1, 0);
        if (expb_q.size() != 0) begin
          ec = expb_q.pop_front();
          check(cyc == ec, "b_resp_cycle", cyc, ec);
          check(bus_b.i_rdata == 32'h1234_5678, "b_resp_data", bus_b.i_rdata, 32'h1234_5678);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_acc(input bit port);
    int n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!(port ? acc_d : acc_i) && n < 50);
    check(n < 50, "accept_timeout", n, 50);
  endtask

  task automatic send_i(input logic [31:0] a);
    bus_a.i_req = 1'b1; bus_a.i_addr = a;
    wait_acc(1'b0);
    bus_a.i_req = 1'b0;
  endtask

  task automatic send_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] len);
    bus_a.d_req = 1'b1; bus_a.d_we = we; bus_a.d_addr = a; bus_a.d_wdata = wd; bus_a.d_len = len;
    wait_acc(1'b1);
    bus_a.d_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check(n < 100, "drain_timeout", n, 100);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, g0;
    reset_n = 1'b1;
    bus_a.i_req = 0; bus_a.i_addr = 0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_addr = 0; bus_a.d_wdata = 0; bus_a.d_len = 0;
    bus_b.i_req = 0; bus_b.i_addr = 0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_addr = 0; bus_b.d_wdata = 0; bus_b.d_len = 0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;

    // directed fetch, store, load-back and back-to-back mixed traffic
    send_i(32'h10);
    wait_idle();
    send_d(1'b1, 32'h40, 32'hDEAD_BEEF, 3'b010);
    wait_idle();
    send_d(1'b0, 32'h40, 32'h0, 3'b010);
    wait_idle();
    send_i(32'h104);
    send_d(1'b0, 32'h108, 32'h0, 3'b001);
    send_i(32'h10C);
    wait_idle();

    // reset while the read is waiting on memory
    bus_a.i_req = 1'b1; bus_a.i_addr = 32'h14;
    @(posedge clock); #1;
    bus_a.i_req = 1'b0;
    @(posedge clock); #1;
    check(bus_a.busy == 1'b1, "busy_before_reset", bus_a.busy, 1);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    send_i(32'h18);
    wait_idle();

    // both ports held: instruction must break through every STARVE_LIMIT grants
    g0 = grant_log.size();
    bus_a.i_req = 1'b1; bus_a.i_addr = rand_addr();
    bus_a.d_req = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = rand_addr();
    n = 0;
    while (grant_log.size() - g0 < 15 && n < 200) begin
      @(posedge clock); #1;
      n++;
      if (acc_i) bus_a.i_addr = rand_addr();
      if (acc_d) begin
        bus_a.d_we = 1'($urandom_range(0, 1)); bus_a.d_addr = rand_addr();
        bus_a.d_wdata = $urandom; bus_a.d_len = 3'($urandom_range(0, 7));
      end
    end
    bus_a.i_req = 1'b0; bus_a.d_req = 1'b0;
    check(n < 200, "starve_timeout", n, 200);
    for (int k = 0; k < 15; k++)
      check(grant_log[g0+k] == ((k % 5) == 4), $sformatf("grant_seq_%0d", k), grant_log[g0+k], ((k % 5) == 4));
    wait_idle();

    // random traffic with occasional dropped requests
    for (int c = 0; c < 600; c++) begin
      @(posedge clock); #1;
      if (bus_a.i_req && !acc_i) begin
        if ($urandom_range(0, 15) == 0) bus_a.i_req = 1'b0;
      end else begin
        bus_a.i_req = ($urandom_range(0, 2) == 0); bus_a.i_addr = rand_addr();
      end
      if (bus_a.d_req && !acc_d) begin
        if ($urandom_range(0, 15) == 0) bus_a.d_req = 1'b0;
      end else begin
        bus_a.d_req = ($urandom_range(0, 1) == 0); bus_a.d_we = 1'($urandom_range(0, 1));
        bus_a.d_addr = rand_addr(); bus_a.d_wdata = $urandom; bus_a.d_len = 3'($urandom_range(0, 7));
      end
    end
    bus_a.i_req = 1'b0; bus_a.d_req = 1'b0;
    wait_idle();

    // latency-3 instance: held fetch request, accepts every 5 cycles
    bus_b.i_addr = 32'h20; bus_b.i_req = 1'b1;
    n = 0;
    while (acc_b_q.size() < 3 && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    bus_b.i_req = 1'b0;
    check(n < 60, "b_accept_timeout", n, 60);
    n = 0;
    while (expb_q.size() != 0 && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    check(n < 60, "b_drain_timeout", n, 60);
    check(acc_b_q[1] - acc_b_q[0] == 5, "b_accept_gap_1", acc_b_q[1] - acc_b_q[0], 5);
    check(acc_b_q[2] - acc_b_q[0] == 10, "b_accept_gap_2", acc_b_q[2] - acc_b_q[0], 10);
    repeat (3) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
